// File: rtl/atm_dispense_arbiter.sv
// Round-robin arbiter sharing one note dispenser among N_REQ ATM sessions.
// Checks each withdrawal against the vault inventory, then pulses one note per cycle.
module atm_dispense_arbiter #(
  parameter int N_REQ      = 4,
  parameter int AMT_W      = 6,
  parameter int VAULT_W    = 12,
  parameter int INIT_NOTES = 1000,
  parameter int MAX_NOTES  = 40
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*AMT_W-1:0]   amount,
  input  logic                     refill_valid,
  input  logic [VAULT_W-1:0]       refill_notes,
  output logic [N_REQ-1:0]         grant,
  output logic                     note_pulse,
  output logic                     done,
  output logic                     reject,
  output logic                     busy,
  output logic [VAULT_W-1:0]       vault_count
);

  localparam int          PW    = $clog2(N_REQ);
  localparam logic [31:0] MAX_U = MAX_NOTES;

  typedef enum logic [2:0] {IDLE, CHECK, DISPENSE, DONE, REJECT} state_e;

  state_e               state_q, state_d;
  logic [N_REQ-1:0]     grant_q, grant_d;
  logic [AMT_W-1:0]     rem_q, rem_d;
  logic [VAULT_W-1:0]   vault_q, vault_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]        idx_q, idx_d;

  logic [PW-1:0]        win;
  logic                 win_vld;
  int                   cand;
  logic                 chk_fail;
  logic [VAULT_W:0]     vsum;

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    cand    = 0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      cand = (int'(rr_ptr_q) + off) % N_REQ;
      if (req[cand[PW-1:0]]) begin
        win     = cand[PW-1:0];
        win_vld = 1'b1;
      end
    end
  end

  // Uses the pre-refill inventory; rem is bounded by it so DISPENSE cannot underflow.
  always_comb begin
    chk_fail = (rem_q == '0) ||
               (32'(rem_q) > MAX_U) ||
               (32'(rem_q) > 32'(vault_q));
  end

  // Refill and dispense decrement combine in one saturating update.
  always_comb begin
    vsum = {1'b0, vault_q}
         + (refill_valid ? {1'b0, refill_notes} : '0)
         - ((state_q == DISPENSE) ? (VAULT_W+1)'(1) : '0);
    vault_d = vsum[VAULT_W] ? '1 : vsum[VAULT_W-1:0];
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rem_d    = rem_q;
    rr_ptr_d = rr_ptr_q;
    idx_d    = idx_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          grant_d = N_REQ'(1) << win;
          idx_d   = win;
          rem_d   = amount[int'(win)*AMT_W +: AMT_W];
          state_d = CHECK;
        end
      end
      CHECK: begin
        state_d = chk_fail ? REJECT : DISPENSE;
      end
      DISPENSE: begin
        rem_d = rem_q - 1'b1;
        if (rem_q == AMT_W'(1)) state_d = DONE;
      end
      DONE, REJECT: begin
        rr_ptr_d = (idx_q == PW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
        grant_d  = '0;
        state_d  = IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rem_q    <= '0;
      vault_q  <= VAULT_W'(INIT_NOTES);
      rr_ptr_q <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rem_q    <= rem_d;
      vault_q  <= vault_d;
      rr_ptr_q <= rr_ptr_d;
      idx_q    <= idx_d;
    end
  end

  assign grant       = grant_q;
  assign note_pulse  = (state_q == DISPENSE);
  assign done        = (state_q == DONE);
  assign reject      = (state_q == REJECT);
  assign busy        = (state_q != IDLE);
  assign vault_count = vault_q;

endmodule

// File: tb/tb_atm_dispense_arbiter.sv
// Scoreboard bench: stimulus predicts each service outcome from the arbitration rules,
// a negedge monitor checks completions, note counts, timing and invariants.
module tb_atm_dispense_arbiter;
  localparam int N = 4, AW = 6, VW = 12, INIT = 1000, MAXN = 40;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]    req;
  logic [N*AW-1:0] amount;
  logic            refill_valid;
  logic [VW-1:0]   refill_notes;
  logic [N-1:0]    grant;
  logic            note_pulse, done, reject, busy;
  logic [VW-1:0]   vault_count;

  atm_dispense_arbiter #(.N_REQ(N), .AMT_W(AW), .VAULT_W(VW), .INIT_NOTES(INIT), .MAX_NOTES(MAXN)) dut (
    .clk(clk), .rst(rst), .req(req), .amount(amount), .refill_valid(refill_valid),
    .refill_notes(refill_notes), .grant(grant), .note_pulse(note_pulse), .done(done),
    .reject(reject), .busy(busy), .vault_count(vault_count));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int idx; bit ok; int notes; int vault; int gcyc; int ecyc;} exp_t;
  exp_t q[$];
  exp_t mon_e;

  int tests = 0, fails = 0;
  int m_ptr = 0, m_vault = INIT;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 4095) ? 4095 : v;
  endfunction

  function automatic logic [N*AW-1:0] setamt(input logic [N*AW-1:0] av, input int s, input int k);
    av[s*AW +: AW] = AW'(k);
    return av;
  endfunction

  function automatic logic [N*AW-1:0] all_amt(input int k);
    logic [N*AW-1:0] av = '0;
    for (int i = 0; i < N; i++) av[i*AW +: AW] = AW'(k);
    return av;
  endfunction

  function automatic logic [N*AW-1:0] rand_amt();
    logic [N*AW-1:0] av = '0;
    for (int i = 0; i < N; i++)
      av[i*AW +: AW] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 63)) : AW'($urandom_range(1, 12));
    return av;
  endfunction

  // Monitor
  bit in_svc = 0;
  int gcyc_m = 0, notes_m = 0;
  always @(negedge clk) begin
    if (rst) begin
      in_svc = 0;
    end else begin
      chk("grant_onehot", int'($countones(grant) <= 1), 1);
      chk("busy_vs_grant", int'(busy), int'(grant != '0));
      chk("done_reject_excl", int'(done && reject), 0);
      if (note_pulse) chk("pulse_needs_grant", int'(grant != '0), 1);
      if (grant == '0) in_svc = 0;
      if (grant != '0 && !in_svc) begin
        in_svc = 1; gcyc_m = cyc; notes_m = 0;
      end
      if (note_pulse) notes_m++;
      if (done || reject) begin
        if (q.size() == 0) chk("unexpected_completion", 1, 0);
        else begin
          mon_e = q.pop_front();
          chk("grant_idx", int'(grant), 1 << mon_e.idx);
          chk("outcome_done", int'(done), int'(mon_e.ok));
          chk("note_count", notes_m, mon_e.notes);
          chk("vault_after", int'(vault_count), mon_e.vault);
          chk("grant_rise_cyc", gcyc_m, mon_e.gcyc);
          chk("complete_cyc", cyc, mon_e.ecyc);
        end
        in_svc = 0;
      end
    end
  end

  // Issue a request pattern; one_shot drops req after the arbitration edge and scrambles amounts.
  task automatic run(input logic [N-1:0] rq, input logic [N*AW-1:0] av, input int count,
                     input bit one_shot, input int refill_at, input int refill_val);
    int c0, cur, w, k;
    bit ok;
    exp_t e;
    @(negedge clk);
    req = rq; amount = av; c0 = cyc; cur = cyc;
    for (int j = 0; j < count; j++) begin
      w = -1;
      for (int off = N - 1; off >= 0; off--) if (rq[(m_ptr + off) % N]) w = (m_ptr + off) % N;
      k = int'(av[w*AW +: AW]);
      ok = (k != 0) && (k <= MAXN) && (k <= m_vault);
      e.idx = w; e.ok = ok; e.notes = ok ? k : 0;
      e.gcyc = cur + 1;
      e.ecyc = ok ? cur + k + 2 : cur + 2;
      if (ok) m_vault -= k;
      if (refill_at >= 0) m_vault = sat(m_vault + refill_val);
      e.vault = m_vault;
      q.push_back(e);
      m_ptr = (w + 1) % N;
      cur = e.ecyc + 1;
    end
    for (int t = 0; t < 100 * count + 100 && q.size() != 0; t++) begin
      @(negedge clk);
      if (one_shot) begin req = '0; amount = (N*AW)'($urandom); end
      refill_valid = (refill_at >= 0) && (cyc == c0 + refill_at);
      refill_notes = VW'(refill_val);
    end
    if (q.size() != 0) begin
      chk("completion_timeout", q.size(), 0);
      q.delete();
    end
    req = '0; refill_valid = 1'b0;
  endtask

  task automatic refill(input int r);
    @(negedge clk);
    refill_valid = 1'b1; refill_notes = VW'(r);
    @(negedge clk);
    refill_valid = 1'b0;
    m_vault = sat(m_vault + r);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = '0; amount = '0; refill_valid = 1'b0; refill_notes = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0; m_vault = INIT; q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    logic [N-1:0] rq;
    rst = 1'b1; req = '0; amount = '0; refill_valid = 1'b0; refill_notes = '0;
    #1;
    chk("reset_grant", int'(grant), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_pulses", int'({note_pulse, done, reject}), 0);
    chk("reset_vault", int'(vault_count), 1000);
    do_reset();

    // Single session, 3 notes
    run(4'b0100, setamt(all_amt(9), 2, 3), 1, 1, -1, 0);
    chk("t1_vault", int'(vault_count), 997);

    // All sessions held, one note each: round-robin 0,1,2,3,0
    do_reset();
    run(4'b1111, all_amt(1), 5, 0, -1, 0);

    // Rejections: zero and above max
    run(4'b0001, setamt(all_amt(5), 0, 0), 1, 1, -1, 0);
    run(4'b1000, setamt(all_amt(5), 3, 41), 1, 1, -1, 0);
    chk("t3_vault_unchanged", int'(vault_count), 995);

    // Refill of 10 during a 4-note dispense
    do_reset();
    run(4'b0010, setamt(all_amt(2), 1, 4), 1, 1, 3, 10);
    chk("t4_vault_refill_mid", int'(vault_count), 1006);
    refill(4000);
    chk("t4_saturate", int'(vault_count), 4095);
    refill(1);
    chk("t4_saturate_hold", int'(vault_count), 4095);
    run(4'b0001, setamt(all_amt(2), 0, 5), 1, 1, -1, 0);

    // req dropped and amount scrambled mid-service
    run(4'b0010, setamt(all_amt(30), 1, 7), 1, 1, -1, 0);

    // Drain vault to 5, then reject over-inventory request
    do_reset();
    for (int i = 0; i < 24; i++) run(N'(1) << $urandom_range(0, N-1), all_amt(40), 1, 1, -1, 0);
    run(4'b0100, all_amt(35), 1, 1, -1, 0);
    chk("drain_vault", int'(vault_count), 5);
    run(4'b0001, all_amt(6), 1, 1, -1, 0);
    chk("over_vault_unchanged", int'(vault_count), 5);
    run(4'b0010, all_amt(5), 1, 1, -1, 0);
    run(4'b1000, all_amt(1), 1, 1, -1, 0);
    chk("empty_vault", int'(vault_count), 0);

    // Reset mid-dispense
    do_reset();
    run(4'b0001, all_amt(2), 1, 1, -1, 0);
    @(negedge clk);
    req = 4'b0100; amount = setamt(all_amt(3), 2, 5); c = cyc;
    @(negedge clk);
    req = '0;
    for (int t = 0; t < 10 && cyc != c + 3; t++) @(negedge clk);
    chk("t5_in_dispense", int'(note_pulse), 1);
    rst = 1'b1;
    #1;
    chk("t5_grant_clear", int'(grant), 0);
    chk("t5_outputs_clear", int'({note_pulse, done, reject, busy}), 0);
    chk("t5_vault_restored", int'(vault_count), 1000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; m_ptr = 0; m_vault = INIT; q.delete();
    run(4'b1001, all_amt(2), 1, 1, -1, 0);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) refill($urandom_range(0, 400));
      rq = N'($urandom_range(1, (1 << N) - 1));
      if ($urandom_range(0, 5) == 0) begin
        logic [N*AW-1:0] av = '0;
        for (int s = 0; s < N; s++) av[s*AW +: AW] = AW'($urandom_range(1, 6));
        run(rq, av, $urandom_range(2, 4), 0, -1, 0);
      end else begin
        run(rq, rand_amt(), 1, 1, -1, 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
